autosym_scan_ctrl: RTL

- Sequencer for one 5-input, 1-output combinational function from the benchmark netlists (restricted-PLA, mockturtle-optimised blocks).
- Drives the function's inputs through all 2^N_IN vectors and captures the truth table.
- Then computes the function's autosymmetry linear space L = {alpha : f(x) = f(x XOR alpha) for all x} and its degree k = log2|L|.
- Sits between a bench or host (start/done handshake) and the function under test (FUT), which hangs off fn_x/fn_y.

---
 rtl/autosym_pkg.sv | 29 ++
 rtl/autosym_scan_ctrl_if.sv | 46 ++++
 rtl/tt_xor_permute.sv | 15 +
 rtl/autosym_scan_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/autosym_pkg.sv
// Shared types and helpers for the autosymmetry scan controller.
package autosym_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Deepest FUT pipeline the scan counter width is sized for.
  localparam int unsigned LAT_MAX = 3;

  // Truth-table width for an n-input function.
  function automatic int unsigned tw(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Position of the single set bit of a one-hot value (0 if none set).
  function automatic logic [2:0] log2_onehot(input logic [5:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/autosym_scan_ctrl_if.sv
// Host/FUT-facing bundle of the autosymmetry scan controller.
interface autosym_scan_ctrl_if #(
  parameter int N_IN = 5
);
  localparam int TW = 1 << N_IN;

  logic            start;
  logic            busy;
  logic            done;
  logic            result_valid;
  logic [N_IN-1:0] fn_x;
  logic            fn_y;
  logic [TW-1:0]   tt;
  logic [TW-1:0]   lspace;
  logic [N_IN:0]   lcount;
  logic [2:0]      degree;

  // Host side plus the FUT hanging off fn_x/fn_y.
  modport master (
    output start,
    output fn_y,
    input  busy,
    input  done,
    input  result_valid,
    input  fn_x,
    input  tt,
    input  lspace,
    input  lcount,
    input  degree
  );

  // Controller side.
  modport slave (
    input  start,
    input  fn_y,
    output busy,
    output done,
    output result_valid,
    output fn_x,
    output tt,
    output lspace,
    output lcount,
    output degree
  );

endinterface

// File: rtl/tt_xor_permute.sv
// Combinational XOR-permutation of a truth table: p[i] = tt[i ^ alpha].
module tt_xor_permute #(
  parameter int N_IN = 5
) (
  input  logic [(1<<N_IN)-1:0] tt,
  input  logic [N_IN-1:0]      alpha,
  output logic [(1<<N_IN)-1:0] p
);

  for (genvar i = 0; i < (1 << N_IN); i++) begin : g_bit
    localparam logic [N_IN-1:0] IDX = N_IN'(i);
    assign p[i] = tt[IDX ^ alpha];
  end

endmodule

// File: rtl/autosym_scan_ctrl.sv
// Scans a combinational function through all input vectors, captures its
// truth table, then finds the autosymmetry space L and its degree.
module autosym_scan_ctrl
  import autosym_pkg::*;
#(
  parameter int N_IN = 5,
  parameter int LAT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  autosym_scan_ctrl_if.slave   bus
);

  localparam int TW = int'(tw(N_IN));

  localparam logic [N_IN+1:0] SCAN_LAST  = (N_IN+2)'(TW + LAT - 1);
  localparam logic [N_IN+1:0] LAT_W      = (N_IN+2)'(LAT);
  localparam logic [N_IN:0]   ALPHA_LAST = (N_IN+1)'(TW - 1);
  localparam logic [N_IN-1:0] FN_X_LAST  = '1;

  state_e          state_q, state_d;
  logic [N_IN+1:0] scan_cnt_q, scan_cnt_d;
  logic [N_IN+1:0] samp_idx;
  logic [N_IN:0]   alpha_q, alpha_d;
  logic [N_IN-1:0] fn_x_q, fn_x_d;
  logic [TW-1:0]   tt_q, tt_d;
  logic [TW-1:0]   lspace_q, lspace_d;
  logic [TW-1:0]   perm;
  logic [N_IN:0]   lcount_q, lcount_d;
  logic [2:0]      degree_q, degree_d;
  logic            rv_q, rv_d;
  logic            eq;
  logic [5:0]      lcount_ext;

  // Sample index trails the scan counter by the FUT latency. During the
  // first LAT cycles the subtraction wraps to a value >= TW, so no table
  // bit matches and nothing is written.
  assign samp_idx = scan_cnt_q - LAT_W;

  tt_xor_permute #(.N_IN(N_IN)) u_perm (
    .tt    (tt_q),
    .alpha (alpha_q[N_IN-1:0]),
    .p     (perm)
  );

  // Next-state and datapath update for the IDLE/SCAN/CHECK/DONE sequence.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    alpha_d    = alpha_q;
    fn_x_d     = fn_x_q;
    tt_d       = tt_q;
    lspace_d   = lspace_q;
    lcount_d   = lcount_q;
    degree_d   = degree_q;
    rv_d       = rv_q;
    eq         = (perm == tt_q);
    lcount_ext = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SCAN;
          scan_cnt_d = '0;
          fn_x_d     = '0;
          tt_d       = '0;
          lspace_d   = '0;
          lcount_d   = '0;
          degree_d   = '0;
          rv_d       = 1'b0;
        end
      end

      SCAN: begin
        for (int i = 0; i < TW; i++) begin
          if (samp_idx == (N_IN+2)'(i)) tt_d[i] = bus.fn_y;
        end
        if (scan_cnt_q == SCAN_LAST) begin
          state_d    = CHECK;
          scan_cnt_d = '0;
          fn_x_d     = '0;
          alpha_d    = '0;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
          if (fn_x_q != FN_X_LAST) fn_x_d = fn_x_q + 1'b1;
        end
      end

      CHECK: begin
        for (int a = 0; a < TW; a++) begin
          if (alpha_q == (N_IN+1)'(a)) lspace_d[a] = eq;
        end
        if (eq) lcount_d = lcount_q + 1'b1;
        if (alpha_q == ALPHA_LAST) begin
          // Degree and valid are settled on DONE entry so they are
          // already visible during the done pulse.
          state_d                = DONE;
          rv_d                   = 1'b1;
          lcount_ext[N_IN:0]     = lcount_d;
          degree_d               = log2_onehot(lcount_ext);
        end else begin
          alpha_d = alpha_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters, FUT drive and result registers; reset aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      alpha_q    <= '0;
      fn_x_q     <= '0;
      tt_q       <= '0;
      lspace_q   <= '0;
      lcount_q   <= '0;
      degree_q   <= '0;
      rv_q       <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      alpha_q    <= alpha_d;
      fn_x_q     <= fn_x_d;
      tt_q       <= tt_d;
      lspace_q   <= lspace_d;
      lcount_q   <= lcount_d;
      degree_q   <= degree_d;
      rv_q       <= rv_d;
    end
  end

  assign bus.busy         = (state_q == SCAN) || (state_q == CHECK);
  assign bus.done         = (state_q == DONE);
  assign bus.result_valid = rv_q;
  assign bus.fn_x         = fn_x_q;
  assign bus.tt           = tt_q;
  assign bus.lspace       = lspace_q;
  assign bus.lcount       = lcount_q;
  assign bus.degree       = degree_q;

endmodule
